vlb_ttw_mux: RTL

//   Shares one translation-table walker (TTW) among N_CH VLB miss channels.
//   - Buffers one miss per channel and arbitrates round-robin into the walker.
//   - Tags each walker request with the channel number in the index MSBs.
//   - Routes walker results and busy back to the owning channel by that tag.
//   - Merges channel kills: kill[0] is ORed; a flush (kill[1]) is issued only once all channels request it.

---
 rtl/vlb_ttw_mux_pkg.sv | 22 ++
 rtl/vlb_ttw_mux_if.sv | 30 +++
 rtl/vlb_ttw_mux_chk.sv | 18 +
 rtl/vlb_ttw_mux_rr_arb.sv | 85 ++++++++
 rtl/vlb_ttw_mux.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/vlb_ttw_mux_pkg.sv
// Shared types and helpers for the VLB-to-walker multiplexer (package vlb_pkg).
package vlb_pkg;

    typedef logic [1:0] vlb_kill_t;
    localparam int KILL_DROP  = 0;
    localparam int KILL_FLUSH = 1;

    localparam int TTW_MW = 52;
    localparam int TTW_AW = 8;

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [TTW_MW-1:0] mpn;
        logic [TTW_AW-1:0] attr;
    } ttw_res_t;

    function automatic int chan_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/vlb_ttw_mux_if.sv
// Walker-side bus: request handshake, kill, busy and result fields.
interface vlb_ttw_mux_if #(
    parameter int IDXW = 6,
    parameter int VW   = 52,
    parameter int MW   = 52,
    parameter int AW   = 8
);
    logic            req_valid;
    logic            req_ready;
    logic [IDXW-1:0] req_idx;
    logic [VW-1:0]   req_vpn;
    logic [2:0]      kill;
    logic            busy;
    logic            res_valid;
    logic [IDXW-1:0] res_idx;
    logic            res_vld;
    logic            res_err;
    logic [MW-1:0]   res_mpn;
    logic [AW-1:0]   res_attr;

    modport master (
        output req_valid, req_idx, req_vpn, kill,
        input  req_ready, busy, res_valid, res_idx, res_vld, res_err, res_mpn, res_attr
    );

    modport slave (
        input  req_valid, req_idx, req_vpn, kill,
        output req_ready, busy, res_valid, res_idx, res_vld, res_err, res_mpn, res_attr
    );
endinterface

// File: rtl/vlb_ttw_mux_chk.sv
// Property checker for vlb_ttw_mux: walker tags must name an existing channel.
module vlb_ttw_mux_chk #(
    parameter int N_CH = 2,
    parameter int CW   = 1
) (
    input logic          clock,
    input logic          reset,
    input logic          res_valid_i,
    input logic          busy_i,
    input logic [CW-1:0] tag_i
);

    a_tag_in_range: assert property (
        @(posedge clock) disable iff (reset)
        (res_valid_i || busy_i) |-> (int'(tag_i) < N_CH)
    );

endmodule

// File: rtl/vlb_ttw_mux_rr_arb.sv
// Round-robin arbiter (module vlb_rr_arb) with one-hot grant that stays locked
// while the granted request is stalled, unless that request is withdrawn.
module vlb_rr_arb
    import vlb_pkg::*;
#(
    parameter int  N  = 2,
    localparam int CW = chan_w(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    input  logic          hold_i,
    output logic [N-1:0]  grant_o,
    output logic [CW-1:0] grant_idx_o
);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic          lock_q;
    logic [CW-1:0] lock_idx_q;
    logic [N-1:0]  grant_s;
    logic [CW-1:0] gidx_s;
    logic          found_s;
    logic [CW:0]   sum_s;
    logic [CW-1:0] cand_s;

    // Grant selection: locked winner first, otherwise first request at or after ptr.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        if (lock_q && req_i[lock_idx_q]) begin
            grant_s[lock_idx_q] = 1'b1;
            gidx_s              = lock_idx_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                sum_s = {1'b0, ptr_q} + (CW+1)'(k);
                if (sum_s >= (CW+1)'(N)) begin
                    sum_s = sum_s - (CW+1)'(N);
                end else begin
                    sum_s = sum_s;
                end
                cand_s = sum_s[CW-1:0];
                if (!found_s && req_i[cand_s]) begin
                    grant_s[cand_s] = 1'b1;
                    gidx_s          = cand_s;
                    found_s         = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Pointer moves one past the winner on a completed handshake.
    always_comb begin
        if (!advance_i) begin
            ptr_d = ptr_q;
        end else if (gidx_s == CW'(N-1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gidx_s + CW'(1);
        end
    end

    // Pointer and grant-lock state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= hold_i;
            lock_idx_q <= gidx_s;
        end
    end

    assign grant_o     = grant_s;
    assign grant_idx_o = gidx_s;

endmodule

// File: rtl/vlb_ttw_mux.sv
// Shares one translation-table walker among N_CH VLB miss channels.
// Optional performance counters are built when VLB_MUX_PERF_EN is defined.
module vlb_ttw_mux
    import vlb_pkg::*;
#(
    parameter int  N_CH = 2,
    parameter int  IW   = 5,
    parameter int  VW   = 52,
    parameter int  MW   = 52,
    parameter int  AW   = 8,
    localparam int CW   = chan_w(N_CH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_CH-1:0]    ch_req_valid_i,
    output logic [N_CH-1:0]    ch_req_ready_o,
    input  logic [N_CH*IW-1:0] ch_req_idx_i,
    input  logic [N_CH*VW-1:0] ch_req_vpn_i,
    input  logic [N_CH*2-1:0]  ch_kill_i,
    vlb_ttw_mux_if.master      ttw,
    output logic [N_CH-1:0]    ch_res_valid_o,
    output logic [IW-1:0]      ch_res_idx_o,
    output logic               ch_res_vld_o,
    output logic               ch_res_err_o,
    output logic [MW-1:0]      ch_res_mpn_o,
    output logic [AW-1:0]      ch_res_attr_o,
    output logic [N_CH-1:0]    ch_busy_o,
    output logic [N_CH*32-1:0] perf_grant_o,
    output logic [N_CH*32-1:0] perf_stall_o
);

    logic [N_CH-1:0] full_q, full_d;
    logic [N_CH-1:0] flush_q, flush_d;
    logic [IW-1:0]   idx_q [N_CH];
    logic [IW-1:0]   idx_d [N_CH];
    logic [VW-1:0]   vpn_q [N_CH];
    logic [VW-1:0]   vpn_d [N_CH];

    vlb_kill_t       kill_s [N_CH];
    logic [N_CH-1:0] kill_drop_s;
    logic [N_CH-1:0] kill_flush_s;
    logic            flush_all_s;
    logic            kill_any_s;
    logic [N_CH-1:0] arb_req_s;
    logic [N_CH-1:0] grant_s;
    logic [CW-1:0]   grant_idx_s;
    logic            req_valid_s;
    logic            handshake_s;
    logic [N_CH-1:0] ready_s;
    logic [N_CH-1:0] load_s;
    logic [IW-1:0]   req_idx_s;
    logic [VW-1:0]   req_vpn_s;
    logic [CW-1:0]   res_tag_s;

    // Unpack per-channel kill pairs.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            kill_s[i]       = ch_kill_i[2*i +: 2];
            kill_drop_s[i]  = kill_s[i][KILL_DROP];
            kill_flush_s[i] = kill_s[i][KILL_FLUSH];
        end
    end

    // A flush reaches the walker only once every channel has asked for it.
    assign flush_all_s = &(kill_flush_s | flush_q);
    assign kill_any_s  = |kill_drop_s;
    assign arb_req_s   = full_q & ~kill_drop_s & {N_CH{~flush_all_s}};

    vlb_rr_arb #(.N(N_CH)) u_arb (
        .clock       (clock),
        .reset       (reset),
        .req_i       (arb_req_s),
        .advance_i   (handshake_s),
        .hold_i      (req_valid_s & ~ttw.req_ready),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    assign req_valid_s = |grant_s;
    assign handshake_s = req_valid_s & ttw.req_ready;

    // Walker request fields from the one-hot granted slot.
    always_comb begin
        req_idx_s = '0;
        req_vpn_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            req_idx_s = req_idx_s | (idx_q[i] & {IW{grant_s[i]}});
            req_vpn_s = req_vpn_s | (vpn_q[i] & {VW{grant_s[i]}});
        end
    end

    assign ttw.req_valid = req_valid_s;
    assign ttw.req_idx   = {grant_idx_s, req_idx_s};
    assign ttw.req_vpn   = req_vpn_s;
    assign ttw.kill      = {flush_all_s, flush_all_s, kill_any_s};

    assign ready_s        = (~full_q | (grant_s & {N_CH{ttw.req_ready}})) &
                            ~kill_drop_s & {N_CH{~flush_all_s}};
    assign load_s         = ch_req_valid_i & ready_s;
    assign ch_req_ready_o = ready_s;

    // Slot and flush-request next state; kill outranks load, load outranks drain.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            idx_d[i] = idx_q[i];
            vpn_d[i] = vpn_q[i];
            if (flush_all_s || kill_drop_s[i]) begin
                full_d[i] = 1'b0;
            end else if (load_s[i]) begin
                full_d[i] = 1'b1;
                idx_d[i]  = ch_req_idx_i[i*IW +: IW];
                vpn_d[i]  = ch_req_vpn_i[i*VW +: VW];
            end else if (grant_s[i] && ttw.req_ready) begin
                full_d[i] = 1'b0;
            end else begin
                full_d[i] = full_q[i];
            end
            if (flush_all_s) begin
                flush_d[i] = 1'b0;
            end else begin
                flush_d[i] = flush_q[i] | kill_flush_s[i];
            end
        end
    end

    // Slot storage and pending flush requests.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q  <= '0;
            flush_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                idx_q[i] <= '0;
                vpn_q[i] <= '0;
            end
        end else begin
            full_q  <= full_d;
            flush_q <= flush_d;
            idx_q   <= idx_d;
            vpn_q   <= vpn_d;
        end
    end

    assign res_tag_s = ttw.res_idx[IW +: CW];

    // Route result valid and busy to the channel named by the tag.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_res_valid_o[i] = ttw.res_valid & (res_tag_s == CW'(i));
            ch_busy_o[i]      = ttw.busy & (res_tag_s == CW'(i));
        end
    end

    assign ch_res_idx_o  = ttw.res_idx[IW-1:0];
    assign ch_res_vld_o  = ttw.res_vld;
    assign ch_res_err_o  = ttw.res_err;
    assign ch_res_mpn_o  = ttw.res_mpn;
    assign ch_res_attr_o = ttw.res_attr;

`ifdef VLB_MUX_PERF_EN
    logic [31:0] grant_cnt_q [N_CH];
    logic [31:0] stall_cnt_q [N_CH];

    // Per-channel handshake and stall counters, wrapping at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                grant_cnt_q[i] <= 32'd0;
                stall_cnt_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (grant_s[i] && handshake_s) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
                if (full_q[i] && !(grant_s[i] && ttw.req_ready)) begin
                    stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    // Flatten counters onto the perf buses.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            perf_grant_o[i*32 +: 32] = grant_cnt_q[i];
            perf_stall_o[i*32 +: 32] = stall_cnt_q[i];
        end
    end
`else
    assign perf_grant_o = '0;
    assign perf_stall_o = '0;
`endif

    vlb_ttw_mux_chk #(.N_CH(N_CH), .CW(CW)) u_chk (
        .clock       (clock),
        .reset       (reset),
        .res_valid_i (ttw.res_valid),
        .busy_i      (ttw.busy),
        .tag_i       (res_tag_s)
    );

endmodule
